// File: rtl/iiq_issue_select_if.sv
// rtl/iiq_issue_select_if.sv - IIQ dequeue/wakeup/issue port bundle shared by queue, selector and ALU
`ifndef IIQ_N_ENTRIES
`define IIQ_N_ENTRIES 8
`endif
`ifndef IIQ_ENTRY_WIDTH
`define IIQ_ENTRY_WIDTH 32
`endif

interface iiq_issue_select_if #(
    parameter int N_ENTRIES   = `IIQ_N_ENTRIES,
    parameter int ENTRY_WIDTH = `IIQ_ENTRY_WIDTH,
    parameter int TAG_WIDTH   = 6
);
    logic [N_ENTRIES-1:0]                  entry_valid;
    logic [N_ENTRIES-1:0][ENTRY_WIDTH-1:0] entry_douts;
    logic                                  deq_valid;
    logic [ENTRY_WIDTH-1:0]                deq_data;
    logic                                  deq_ready;
    logic [N_ENTRIES-1:0]                  deq_sel_onehot;
    logic [N_ENTRIES-1:0]                  wr_en;
    logic [N_ENTRIES-1:0][ENTRY_WIDTH-1:0] wr_data;
    logic                                  wb0_valid;
    logic                                  wb1_valid;
    logic [TAG_WIDTH-1:0]                  wb0_tag;
    logic [TAG_WIDTH-1:0]                  wb1_tag;
    logic                                  flush;
    logic                                  issue_valid;
    logic [ENTRY_WIDTH-1:0]                issue_data;
    logic                                  issue_ready;

    modport master (
        input  entry_valid, entry_douts, deq_valid, deq_data,
        input  wb0_valid, wb1_valid, wb0_tag, wb1_tag, flush, issue_ready,
        output deq_ready, deq_sel_onehot, wr_en, wr_data, issue_valid, issue_data
    );

    modport slave (
        output entry_valid, entry_douts, deq_valid, deq_data,
        output wb0_valid, wb1_valid, wb0_tag, wb1_tag, flush, issue_ready,
        input  deq_ready, deq_sel_onehot, wr_en, wr_data, issue_valid, issue_data
    );
endinterface

// File: rtl/iiq_issue_select.sv
// rtl/iiq_issue_select.sv - IIQ wakeup, oldest-ready select and one-entry issue register
// Optional same-cycle wakeup bypass into eligibility: define IIQ_WAKEUP_BYPASS_EN.
module iiq_issue_select #(
    parameter int N_ENTRIES   = `IIQ_N_ENTRIES,
    parameter int ENTRY_WIDTH = `IIQ_ENTRY_WIDTH,
    parameter int TAG_WIDTH   = 6
) (
    input  logic                clk,
    input  logic                rst,
    iiq_issue_select_if.master  bus
);
    localparam int PAYLOAD_WIDTH = ENTRY_WIDTH - 2*TAG_WIDTH - 2;
    localparam int S2_RDY        = PAYLOAD_WIDTH;
    localparam int S2_TAG_LSB    = S2_RDY + 1;
    localparam int S1_RDY        = S2_TAG_LSB + TAG_WIDTH;
    localparam int S1_TAG_LSB    = S1_RDY + 1;

    logic [N_ENTRIES-1:0]                  wake_en;
    logic [N_ENTRIES-1:0]                  eligible;
    logic [N_ENTRIES-1:0]                  oldest;
    logic [N_ENTRIES-1:0][ENTRY_WIDTH-1:0] entry_upd;
    logic                                  can_issue;
    logic                                  deq_req;
    logic                                  issue_valid_q, issue_valid_d;
    logic [ENTRY_WIDTH-1:0]                issue_data_q, issue_data_d;

    function automatic logic wb_hit(
        input logic [TAG_WIDTH-1:0] tag,
        input logic v0, input logic [TAG_WIDTH-1:0] t0,
        input logic v1, input logic [TAG_WIDTH-1:0] t1
    );
        return (v0 && (t0 == tag)) || (v1 && (t1 == tag));
    endfunction

    always_comb begin
        wake_en   = '0;
        eligible  = '0;
        entry_upd = bus.entry_douts;
        for (int i = 0; i < N_ENTRIES; i++) begin
            if (bus.entry_valid[i] && !bus.entry_douts[i][S1_RDY] &&
                wb_hit(bus.entry_douts[i][S1_TAG_LSB +: TAG_WIDTH],
                       bus.wb0_valid, bus.wb0_tag, bus.wb1_valid, bus.wb1_tag)) begin
                entry_upd[i][S1_RDY] = 1'b1;
                wake_en[i]           = 1'b1;
            end
            if (bus.entry_valid[i] && !bus.entry_douts[i][S2_RDY] &&
                wb_hit(bus.entry_douts[i][S2_TAG_LSB +: TAG_WIDTH],
                       bus.wb0_valid, bus.wb0_tag, bus.wb1_valid, bus.wb1_tag)) begin
                entry_upd[i][S2_RDY] = 1'b1;
                wake_en[i]           = 1'b1;
            end
`ifdef IIQ_WAKEUP_BYPASS_EN
            eligible[i] = bus.entry_valid[i] & entry_upd[i][S1_RDY] & entry_upd[i][S2_RDY];
`else
            eligible[i] = bus.entry_valid[i] & bus.entry_douts[i][S1_RDY] & bus.entry_douts[i][S2_RDY];
`endif
        end
    end

    // Queue compacts toward index 0, so the lowest set eligible bit is the oldest.
    assign oldest    = eligible & (~eligible + N_ENTRIES'(1));
    assign can_issue = !issue_valid_q || bus.issue_ready;
    assign deq_req   = can_issue && (|eligible) && !bus.flush;

    assign bus.deq_ready      = deq_req;
    assign bus.deq_sel_onehot = deq_req ? oldest : '0;
    assign bus.wr_en          = wake_en & ~bus.deq_sel_onehot;
    assign bus.wr_data        = entry_upd;
    assign bus.issue_valid    = issue_valid_q;
    assign bus.issue_data     = issue_data_q;

    always_comb begin
        issue_valid_d = issue_valid_q;
        issue_data_d  = issue_data_q;
        if (bus.flush) begin
            issue_valid_d = 1'b0;
            issue_data_d  = '0;
        end else if (deq_req && bus.deq_valid) begin
            issue_valid_d        = 1'b1;
            issue_data_d         = bus.deq_data;
            issue_data_d[S1_RDY] = 1'b1;
            issue_data_d[S2_RDY] = 1'b1;
        end else if (issue_valid_q && bus.issue_ready) begin
            issue_valid_d = 1'b0;
            issue_data_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            issue_valid_q <= 1'b0;
            issue_data_q  <= '0;
        end else begin
            issue_valid_q <= issue_valid_d;
            issue_data_q  <= issue_data_d;
        end
    end
endmodule
